// File: rtl/id_pkg.sv
// Shared encodings for the decode/issue stage: operand selects, branch kinds, PC step.
package id_pkg;

  localparam logic [1:0] SRC1_ZERO = 2'b00;
  localparam logic [1:0] SRC1_PC   = 2'b01;
  localparam logic [1:0] SRC1_REG  = 2'b10;

  localparam logic [1:0] SRC2_ZERO = 2'b00;
  localparam logic [1:0] SRC2_IMM  = 2'b01;
  localparam logic [1:0] SRC2_REG  = 2'b10;
  localparam logic [1:0] SRC2_FOUR = 2'b11;

  localparam logic [3:0] BR_NONE = 4'd0;
  localparam logic [3:0] BR_B    = 4'd1;
  localparam logic [3:0] BR_BL   = 4'd2;
  localparam logic [3:0] BR_JIRL = 4'd3;
  localparam logic [3:0] BR_BEQ  = 4'd4;
  localparam logic [3:0] BR_BNE  = 4'd5;
  localparam logic [3:0] BR_BLT  = 4'd6;
  localparam logic [3:0] BR_BGE  = 4'd7;
  localparam logic [3:0] BR_BLTU = 4'd8;
  localparam logic [3:0] BR_BGEU = 4'd9;

  localparam int unsigned PC_INC = 4;

  // Conditional branches compare src1 against the src2 register value.
  function automatic logic br_is_cmp(logic [3:0] br_type);
    return (br_type >= BR_BEQ) && (br_type <= BR_BGEU);
  endfunction

endpackage

// File: rtl/id_operand_resolve.sv
// Resolves one register operand from the bypass sources or the register file.
module id_operand_resolve #(
  parameter int unsigned NUM_BYP = 3,
  parameter int unsigned XLEN    = 32
) (
  input  logic [4:0]              addr_i,
  input  logic [XLEN-1:0]         rf_data_i,
  input  logic [NUM_BYP-1:0]      byp_wen_i,
  input  logic [5*NUM_BYP-1:0]    byp_addr_i,
  input  logic [XLEN*NUM_BYP-1:0] byp_data_i,
  input  logic [NUM_BYP-1:0]      byp_data_ok_i,
  output logic                    ready_o,
  output logic [XLEN-1:0]         data_o
);

  always_comb begin
    ready_o = 1'b1;
    data_o  = rf_data_i;
    if (addr_i == 5'd0) begin
      data_o = '0;
    end else begin
      // Walk oldest to youngest so the lowest matching index has the final say.
      for (int i = int'(NUM_BYP) - 1; i >= 0; i--) begin
        if (byp_wen_i[i] && (byp_addr_i[5*i +: 5] == addr_i)) begin
          ready_o = byp_data_ok_i[i];
          data_o  = byp_data_ok_i[i] ? byp_data_i[XLEN*i +: XLEN] : '0;
        end
      end
    end
  end

endmodule

// File: rtl/id_issue_stage.sv
// Decode/issue stage: operand bypass, hazard stall, branch resolve and redirect.
// Optional hazard-stall counter enabled by defining ID_STALL_CNT_EN.
module id_issue_stage
  import id_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NUM_BYP   = 3,
  parameter int unsigned PAYLOAD_W = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_allow,
  input  logic [4:0]              in_src1_addr,
  input  logic [4:0]              in_src2_addr,
  input  logic [1:0]              in_src1_sel,
  input  logic [1:0]              in_src2_sel,
  input  logic                    in_st_en,
  input  logic [XLEN-1:0]         in_imm,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [XLEN-1:0]         in_pred_pc,
  input  logic [3:0]              in_br_type,
  input  logic [PAYLOAD_W-1:0]    in_payload,
  output logic [4:0]              rf_raddr1,
  output logic [4:0]              rf_raddr2,
  input  logic [XLEN-1:0]         rf_rdata1,
  input  logic [XLEN-1:0]         rf_rdata2,
  input  logic [NUM_BYP-1:0]      byp_wen,
  input  logic [5*NUM_BYP-1:0]    byp_addr,
  input  logic [XLEN*NUM_BYP-1:0] byp_data,
  input  logic [NUM_BYP-1:0]      byp_data_ok,
  output logic                    out_valid,
  input  logic                    out_allow,
  output logic [XLEN-1:0]         out_src1,
  output logic [XLEN-1:0]         out_src2,
  output logic [XLEN-1:0]         out_st_data,
  output logic [XLEN-1:0]         out_pc,
  output logic [PAYLOAD_W-1:0]    out_payload,
  output logic                    redirect_valid,
  output logic [XLEN-1:0]         redirect_pc,
  output logic [31:0]             stall_cycles
);

  logic                 v_q, v_d;
  logic [4:0]           src1_addr_q, src2_addr_q;
  logic [1:0]           src1_sel_q, src2_sel_q;
  logic                 st_en_q;
  logic [XLEN-1:0]      imm_q, pc_q, pred_pc_q;
  logic [3:0]           br_type_q;
  logic [PAYLOAD_W-1:0] payload_q;

  logic            rdy1, rdy2, rdy_st;
  logic [XLEN-1:0] reg1, reg2, reg_st;
  logic            need1, need2, need_st, ready_go, load;
  logic            taken;
  logic [XLEN-1:0] target, next_pc;

  id_operand_resolve #(.NUM_BYP(NUM_BYP), .XLEN(XLEN)) u_res_src1 (
    .addr_i(src1_addr_q), .rf_data_i(rf_rdata1), .byp_wen_i(byp_wen), .byp_addr_i(byp_addr),
    .byp_data_i(byp_data), .byp_data_ok_i(byp_data_ok), .ready_o(rdy1), .data_o(reg1)
  );
  id_operand_resolve #(.NUM_BYP(NUM_BYP), .XLEN(XLEN)) u_res_src2 (
    .addr_i(src2_addr_q), .rf_data_i(rf_rdata2), .byp_wen_i(byp_wen), .byp_addr_i(byp_addr),
    .byp_data_i(byp_data), .byp_data_ok_i(byp_data_ok), .ready_o(rdy2), .data_o(reg2)
  );
  id_operand_resolve #(.NUM_BYP(NUM_BYP), .XLEN(XLEN)) u_res_st (
    .addr_i(src2_addr_q), .rf_data_i(rf_rdata2), .byp_wen_i(byp_wen), .byp_addr_i(byp_addr),
    .byp_data_i(byp_data), .byp_data_ok_i(byp_data_ok), .ready_o(rdy_st), .data_o(reg_st)
  );

  assign rf_raddr1   = src1_addr_q;
  assign rf_raddr2   = src2_addr_q;
  assign out_pc      = pc_q;
  assign out_payload = payload_q;
  assign out_st_data = reg_st;

  assign need1   = (src1_sel_q == SRC1_REG);
  assign need2   = (src2_sel_q == SRC2_REG);
  assign need_st = st_en_q | br_is_cmp(br_type_q);

  assign ready_go  = (~need1 | rdy1) & (~need2 | rdy2) & (~need_st | rdy_st);
  assign out_valid = v_q & ready_go;
  assign in_allow  = ~v_q | (ready_go & out_allow);
  assign load      = in_valid & in_allow;

  always_comb begin
    out_src1 = '0;
    case (src1_sel_q)
      SRC1_PC:  out_src1 = pc_q;
      SRC1_REG: out_src1 = reg1;
      default:  out_src1 = '0;
    endcase
    out_src2 = '0;
    case (src2_sel_q)
      SRC2_IMM:  out_src2 = imm_q;
      SRC2_REG:  out_src2 = reg2;
      SRC2_FOUR: out_src2 = XLEN'(PC_INC);
      default:   out_src2 = '0;
    endcase
  end

  always_comb begin
    taken  = 1'b0;
    target = pc_q + imm_q;
    case (br_type_q)
      BR_B, BR_BL: taken = 1'b1;
      BR_JIRL: begin
        taken  = 1'b1;
        target = out_src1 + imm_q;
      end
      BR_BEQ:  taken = (out_src1 == reg_st);
      BR_BNE:  taken = (out_src1 != reg_st);
      BR_BLT:  taken = ($signed(out_src1) < $signed(reg_st));
      BR_BGE:  taken = ($signed(out_src1) >= $signed(reg_st));
      BR_BLTU: taken = (out_src1 < reg_st);
      BR_BGEU: taken = (out_src1 >= reg_st);
      default: taken = 1'b0;
    endcase
    next_pc = taken ? target : (pc_q + XLEN'(PC_INC));
  end

  assign redirect_pc    = next_pc;
  assign redirect_valid = out_valid & out_allow & (br_type_q != BR_NONE) & (next_pc != pred_pc_q);

  // A redirect flushes whatever pre-decode offers in the same cycle.
  always_comb begin
    v_d = v_q;
    if (redirect_valid) v_d = 1'b0;
    else if (in_allow)  v_d = in_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q         <= 1'b0;
      src1_addr_q <= '0;
      src2_addr_q <= '0;
      src1_sel_q  <= '0;
      src2_sel_q  <= '0;
      st_en_q     <= 1'b0;
      imm_q       <= '0;
      pc_q        <= '0;
      pred_pc_q   <= '0;
      br_type_q   <= '0;
      payload_q   <= '0;
    end else begin
      v_q <= v_d;
      if (load) begin
        src1_addr_q <= in_src1_addr;
        src2_addr_q <= in_src2_addr;
        src1_sel_q  <= in_src1_sel;
        src2_sel_q  <= in_src2_sel;
        st_en_q     <= in_st_en;
        imm_q       <= in_imm;
        pc_q        <= in_pc;
        pred_pc_q   <= in_pred_pc;
        br_type_q   <= in_br_type;
        payload_q   <= in_payload;
      end
    end
  end

`ifdef ID_STALL_CNT_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (v_q && !ready_go && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end
  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_id_issue_stage.sv
// Scoreboard bench for id_issue_stage: bypass priority, stalls, branches, redirect, reset.
module tb_id_issue_stage;
  import id_pkg::*;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned NUM_BYP   = 3;
  localparam int unsigned PAYLOAD_W = 64;
`ifdef ID_STALL_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic in_valid, in_allow, in_st_en;
  logic [4:0] in_src1_addr, in_src2_addr, rf_raddr1, rf_raddr2;
  logic [1:0] in_src1_sel, in_src2_sel;
  logic [XLEN-1:0] in_imm, in_pc, in_pred_pc, rf_rdata1, rf_rdata2;
  logic [3:0] in_br_type;
  logic [PAYLOAD_W-1:0] in_payload, out_payload;
  logic [NUM_BYP-1:0] byp_wen, byp_data_ok;
  logic [5*NUM_BYP-1:0] byp_addr;
  logic [XLEN*NUM_BYP-1:0] byp_data;
  logic out_valid, out_allow, redirect_valid;
  logic [XLEN-1:0] out_src1, out_src2, out_st_data, out_pc, redirect_pc;
  logic [31:0] stall_cycles;

  logic [XLEN-1:0] rf_mem [32];
  always_comb rf_rdata1 = rf_mem[rf_raddr1];
  always_comb rf_rdata2 = rf_mem[rf_raddr2];

  always #5 clk = ~clk;

  id_issue_stage #(.XLEN(XLEN), .NUM_BYP(NUM_BYP), .PAYLOAD_W(PAYLOAD_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_allow(in_allow),
    .in_src1_addr(in_src1_addr), .in_src2_addr(in_src2_addr), .in_src1_sel(in_src1_sel),
    .in_src2_sel(in_src2_sel), .in_st_en(in_st_en), .in_imm(in_imm), .in_pc(in_pc),
    .in_pred_pc(in_pred_pc), .in_br_type(in_br_type), .in_payload(in_payload),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .byp_wen(byp_wen), .byp_addr(byp_addr), .byp_data(byp_data), .byp_data_ok(byp_data_ok),
    .out_valid(out_valid), .out_allow(out_allow), .out_src1(out_src1), .out_src2(out_src2),
    .out_st_data(out_st_data), .out_pc(out_pc), .out_payload(out_payload),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall_cycles(stall_cycles)
  );

  typedef struct {
    logic [XLEN-1:0]      src1;
    logic [XLEN-1:0]      src2;
    logic [XLEN-1:0]      st;
    logic                 chk_st;
    logic [XLEN-1:0]      pc;
    logic [PAYLOAD_W-1:0] payload;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_stall = 32'd0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_src1_addr = '0; in_src2_addr = '0; in_src1_sel = '0;
    in_src2_sel = '0; in_st_en = 1'b0; in_imm = '0; in_pc = '0; in_pred_pc = '0;
    in_br_type = BR_NONE; in_payload = '0; out_allow = 1'b1;
    byp_wen = '0; byp_addr = '0; byp_data = '0; byp_data_ok = '0;
  endtask

  task automatic drive(input logic [1:0] s1sel, input logic [4:0] s1a, input logic [1:0] s2sel,
                       input logic [4:0] s2a, input logic st, input logic [3:0] br,
                       input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm,
                       input logic [XLEN-1:0] pred, input logic [PAYLOAD_W-1:0] pl);
    in_valid = 1'b1; in_src1_sel = s1sel; in_src1_addr = s1a; in_src2_sel = s2sel;
    in_src2_addr = s2a; in_st_en = st; in_br_type = br; in_pc = pc; in_imm = imm;
    in_pred_pc = pred; in_payload = pl;
  endtask

  task automatic push(input logic [XLEN-1:0] s1, input logic [XLEN-1:0] s2,
                      input logic [XLEN-1:0] st, input logic chk, input logic [XLEN-1:0] pc,
                      input logic [PAYLOAD_W-1:0] pl);
    exp_t x;
    x.src1 = s1; x.src2 = s2; x.st = st; x.chk_st = chk; x.pc = pc; x.payload = pl;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (in_allow !== 1'b1) begin errors++;
      $display("FAIL reset_in_allow got %b exp 1", in_allow); end
    checks++; if (redirect_valid !== 1'b0) begin errors++;
      $display("FAIL reset_redirect got %b exp 0", redirect_valid); end
    checks++; if (stall_cycles !== 32'd0) begin errors++;
      $display("FAIL reset_stall_cycles got %0d exp 0", stall_cycles); end
    checks++; if (out_pc !== '0 || rf_raddr1 !== 5'd0) begin errors++;
      $display("FAIL reset_stage_reg got pc %h raddr1 %0d exp 0", out_pc, rf_raddr1); end
  endtask

  // Four back-to-back instructions covering every operand source and bypass priority.
  task automatic test_basic();
    tick();
    byp_wen = 3'b110; byp_addr = {5'd2, 5'd2, 5'd0}; byp_data_ok = 3'b111;
    byp_data = {32'h0000_BBBB, 32'h0000_AAAA, 32'h0};
    for (int k = 0; k <= 4; k++) begin
      case (k)
        0: begin drive(SRC1_PC, 5'd0, SRC2_IMM, 5'd0, 1'b0, BR_NONE, 32'h200, 32'h44, 32'h0,
                       64'hA0); push(32'h200, 32'h44, 32'h0, 1'b0, 32'h200, 64'hA0); end
        1: begin drive(SRC1_REG, 5'd3, SRC2_FOUR, 5'd0, 1'b0, BR_NONE, 32'h204, 32'h0, 32'h0,
                       64'hA1); push(32'h103, 32'h4, 32'h0, 1'b0, 32'h204, 64'hA1); end
        2: begin drive(SRC1_ZERO, 5'd0, SRC2_REG, 5'd4, 1'b1, BR_NONE, 32'h208, 32'h0, 32'h0,
                       64'hA2); push(32'h0, 32'h104, 32'h104, 1'b1, 32'h208, 64'hA2); end
        3: begin drive(SRC1_REG, 5'd2, SRC2_REG, 5'd1, 1'b0, BR_NONE, 32'h20C, 32'h0, 32'h0,
                       64'hFFFF_0000_1234_5678);
                 push(32'hAAAA, 32'h101, 32'h0, 1'b0, 32'h20C, 64'hFFFF_0000_1234_5678); end
        default: in_valid = 1'b0;
      endcase
      #1;
      if (k > 0) begin
        checks++; if (out_valid !== 1'b1 || in_allow !== 1'b1) begin errors++;
          $display("FAIL basic_flow[%0d] got valid %b allow %b exp 1 1", k, out_valid, in_allow); end
        e = sb.pop_front();
        checks++;
        if (out_src1 !== e.src1 || out_src2 !== e.src2 || out_pc !== e.pc ||
            out_payload !== e.payload || (e.chk_st && out_st_data !== e.st)) begin
          errors++;
          $display("FAIL basic_data[%0d] got %h %h %h %h exp %h %h %h %h", k, out_src1, out_src2,
                   out_st_data, out_pc, e.src1, e.src2, e.st, e.pc);
        end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_hazard();
    tick();
    byp_wen = 3'b101; byp_addr = {5'd5, 5'd0, 5'd5}; byp_data = {32'd7, 32'h0, 32'h0};
    byp_data_ok = 3'b100;
    drive(SRC1_REG, 5'd5, SRC2_ZERO, 5'd0, 1'b0, BR_NONE, 32'h400, 32'h0, 32'h0, 64'h55);
    push(32'h11, 32'h0, 32'h0, 1'b0, 32'h400, 64'h55);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (out_valid !== 1'b0 || in_allow !== 1'b0) begin errors++;
        $display("FAIL hazard_stall[%0d] got valid %b allow %b exp 0 0", i, out_valid, in_allow); end
      tick();
    end
    if (CntEn) exp_stall = exp_stall + 32'd3;
    byp_data_ok = 3'b101; byp_data = {32'd7, 32'h0, 32'h11};
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++;
      $display("FAIL hazard_release got valid %b exp 1", out_valid); end
    e = sb.pop_front();
    checks++; if (out_src1 !== e.src1 || out_pc !== e.pc) begin errors++;
      $display("FAIL hazard_data got %h pc %h exp %h pc %h", out_src1, out_pc, e.src1, e.pc); end
    checks++; if (stall_cycles !== exp_stall) begin errors++;
      $display("FAIL hazard_stall_cnt got %0d exp %0d", stall_cycles, exp_stall); end
    tick();
    checks++; if (out_valid !== 1'b0 || in_allow !== 1'b1) begin errors++;
      $display("FAIL hazard_after got valid %b allow %b exp 0 1", out_valid, in_allow); end
    idle();
  endtask

  task automatic test_zero_reg();
    tick();
    byp_wen = 3'b111; byp_addr = '0; byp_data = {3{32'hDEAD_BEEF}}; byp_data_ok = 3'b000;
    drive(SRC1_REG, 5'd0, SRC2_REG, 5'd0, 1'b1, BR_NONE, 32'h500, 32'h0, 32'h0, 64'h77);
    push(32'h0, 32'h0, 32'h0, 1'b1, 32'h500, 64'h77);
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++;
      $display("FAIL zero_reg_valid got %b exp 1", out_valid); end
    e = sb.pop_front();
    checks++; if (out_src1 !== e.src1 || out_src2 !== e.src2 || out_st_data !== e.st) begin
      errors++;
      $display("FAIL zero_reg_data got %h %h %h exp 0", out_src1, out_src2, out_st_data); end
    idle();
  endtask

  task automatic test_branch();
    tick();
    rf_mem[6] = 32'd3; rf_mem[7] = 32'd3; rf_mem[8] = 32'hFFFF_FFFF; rf_mem[9] = 32'd1;
    drive(SRC1_REG, 5'd6, SRC2_IMM, 5'd7, 1'b0, BR_BEQ, 32'h1000, 32'h20, 32'h1004, 64'hB0);
    push(32'd3, 32'h20, 32'd3, 1'b1, 32'h1000, 64'hB0);
    tick();
    // Wrong-path instruction offered during the redirect cycle must be dropped.
    drive(SRC1_PC, 5'd0, SRC2_IMM, 5'd0, 1'b0, BR_NONE, 32'h1004, 32'h1, 32'h0, 64'hDD);
    #1;
    checks++; if (out_valid !== 1'b1 || redirect_valid !== 1'b1 || redirect_pc !== 32'h1020) begin
      errors++; $display("FAIL beq_redirect got v %b r %b pc %h exp 1 1 00001020",
                         out_valid, redirect_valid, redirect_pc); end
    e = sb.pop_front();
    checks++; if (out_src1 !== e.src1 || out_src2 !== e.src2 || out_pc !== e.pc) begin errors++;
      $display("FAIL beq_data got %h %h %h exp %h %h %h", out_src1, out_src2, out_pc,
               e.src1, e.src2, e.pc); end
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || redirect_valid !== 1'b0) begin errors++;
      $display("FAIL beq_flush got v %b r %b exp 0 0", out_valid, redirect_valid); end
    drive(SRC1_REG, 5'd8, SRC2_IMM, 5'd9, 1'b0, BR_BLTU, 32'h2000, 32'h40, 32'h2004, 64'hB1);
    push(32'hFFFF_FFFF, 32'h40, 32'd1, 1'b1, 32'h2000, 64'hB1);
    tick();
    drive(SRC1_REG, 5'd8, SRC2_IMM, 5'd9, 1'b0, BR_BLT, 32'h2010, 32'h40, 32'h2014, 64'hB2);
    push(32'hFFFF_FFFF, 32'h40, 32'd1, 1'b1, 32'h2010, 64'hB2);
    #1;
    checks++; if (out_valid !== 1'b1 || redirect_valid !== 1'b0) begin errors++;
      $display("FAIL bltu_not_taken got v %b r %b exp 1 0", out_valid, redirect_valid); end
    e = sb.pop_front();
    checks++; if (out_src1 !== e.src1 || out_st_data !== e.st || out_pc !== e.pc) begin errors++;
      $display("FAIL bltu_data got %h %h %h exp %h %h %h", out_src1, out_st_data, out_pc,
               e.src1, e.st, e.pc); end
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || redirect_valid !== 1'b1 || redirect_pc !== 32'h2050) begin
      errors++; $display("FAIL blt_taken got v %b r %b pc %h exp 1 1 00002050",
                         out_valid, redirect_valid, redirect_pc); end
    e = sb.pop_front();
    checks++; if (out_pc !== e.pc || out_payload !== e.payload) begin errors++;
      $display("FAIL blt_data got pc %h pl %h exp %h %h", out_pc, out_payload, e.pc, e.payload); end
    drive(SRC1_REG, 5'd3, SRC2_FOUR, 5'd0, 1'b0, BR_JIRL, 32'h3000, 32'h10, 32'h3004, 64'hB3);
    push(32'h103, 32'h4, 32'h0, 1'b0, 32'h3000, 64'hB3);
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL blt_flush got v %b exp 0", out_valid); end
    drive(SRC1_REG, 5'd3, SRC2_FOUR, 5'd0, 1'b0, BR_JIRL, 32'h3000, 32'h10, 32'h3004, 64'hB3);
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h113) begin errors++;
      $display("FAIL jirl_redirect got r %b pc %h exp 1 00000113", redirect_valid, redirect_pc); end
    e = sb.pop_front();
    checks++; if (out_src1 !== e.src1 || out_src2 !== e.src2) begin errors++;
      $display("FAIL jirl_data got %h %h exp %h %h", out_src1, out_src2, e.src1, e.src2); end
    idle();
  endtask

  task automatic test_backpressure();
    tick();
    drive(SRC1_PC, 5'd0, SRC2_IMM, 5'd0, 1'b0, BR_B, 32'h300, 32'h5, 32'h0, 64'hC0);
    push(32'h300, 32'h5, 32'h0, 1'b0, 32'h300, 64'hC0);
    tick();
    in_valid = 1'b0;
    out_allow = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_allow !== 1'b0 || redirect_valid !== 1'b0 ||
          out_src1 !== 32'h300 || out_src2 !== 32'h5 || stall_cycles !== exp_stall) begin
        errors++;
        $display("FAIL backpressure[%0d] got v %b a %b r %b %h %h cnt %0d exp 1 0 0 300 5 %0d",
                 i, out_valid, in_allow, redirect_valid, out_src1, out_src2, stall_cycles,
                 exp_stall);
      end
      tick();
    end
    out_allow = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b1 || in_allow !== 1'b1 || redirect_valid !== 1'b1) begin
      errors++; $display("FAIL backpressure_release got v %b a %b r %b exp 1 1 1",
                         out_valid, in_allow, redirect_valid); end
    e = sb.pop_front();
    checks++; if (out_src1 !== e.src1 || out_payload !== e.payload) begin errors++;
      $display("FAIL backpressure_data got %h %h exp %h %h", out_src1, out_payload,
               e.src1, e.payload); end
    idle();
  endtask

  task automatic test_reset_stall();
    tick();
    byp_wen = 3'b001; byp_addr = {5'd0, 5'd0, 5'd5}; byp_data_ok = 3'b000;
    drive(SRC1_REG, 5'd5, SRC2_ZERO, 5'd0, 1'b0, BR_B, 32'h600, 32'h8, 32'h0, 64'hE0);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || redirect_valid !== 1'b0) begin errors++;
      $display("FAIL reset_stall_hold got v %b r %b exp 0 0", out_valid, redirect_valid); end
    tick();
    reset = 1'b0;
    exp_stall = 32'd0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_allow !== 1'b1 || stall_cycles !== exp_stall) begin
      errors++; $display("FAIL reset_stall_after got v %b a %b cnt %0d exp 0 1 0",
                         out_valid, in_allow, stall_cycles); end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h100 + 32'(i);
    rf_mem[0] = '0;
    test_reset();
    test_basic();
    test_hazard();
    test_zero_reg();
    test_branch();
    test_backpressure();
    test_reset_stall();
    checks++; if (sb.size() != 0) begin errors++;
      $display("FAIL scoreboard_drain got %0d exp 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
